// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pipe_pkg
// Brief    : Shared pipeline control-bundle layout and helpers.
// Revision : 1.0 - initial release
// ============================================================================
package pipe_pkg;

    localparam int CTRL_W = 8;

    localparam int REGDST   = 0;
    localparam int REGWRITE = 1;
    localparam int ALUOP_LO = 2;
    localparam int ALUOP_HI = 3;
    localparam int ALUSRC   = 4;
    localparam int MEMW     = 5;
    localparam int MEMR     = 6;
    localparam int MEMTOREG = 7;

    localparam logic [CTRL_W-1:0] CTRL_BUBBLE = '0;

    typedef enum logic [1:0] {
        ALU_ADD   = 2'b00,
        ALU_SUB   = 2'b01,
        ALU_FUNCT = 2'b10,
        ALU_RSVD  = 2'b11
    } alu_op_e;

    function automatic logic ctrl_has_side_effect(input logic [CTRL_W-1:0] ctrl);
        return ctrl[REGWRITE] | ctrl[MEMW];
    endfunction

    function automatic alu_op_e ctrl_alu_op(input logic [CTRL_W-1:0] ctrl);
        return alu_op_e'(ctrl[ALUOP_HI:ALUOP_LO]);
    endfunction

endpackage : pipe_pkg
`default_nettype wire

// File: rtl/pipe_entry_reg.sv
`default_nettype none
// ============================================================================
// Module   : pipe_entry_reg
// Brief    : One pipeline entry (valid + control + payload), falling-edge.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_entry_reg
    import pipe_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int RADDR_W = 5,
    parameter int CTRL_W  = pipe_pkg::CTRL_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clear,
    input  logic               load,
    input  logic [CTRL_W-1:0]  d_ctrl,
    input  logic [DATA_W-1:0]  d_rs,
    input  logic [DATA_W-1:0]  d_rt,
    input  logic [RADDR_W-1:0] d_rt_addr,
    input  logic [RADDR_W-1:0] d_rd_addr,
    input  logic [DATA_W-1:0]  d_imm,
    output logic               valid,
    output logic [CTRL_W-1:0]  q_ctrl,
    output logic [DATA_W-1:0]  q_rs,
    output logic [DATA_W-1:0]  q_rt,
    output logic [RADDR_W-1:0] q_rt_addr,
    output logic [RADDR_W-1:0] q_rd_addr,
    output logic [DATA_W-1:0]  q_imm
);

    logic               r_valid;
    logic [CTRL_W-1:0]  r_ctrl;
    logic [DATA_W-1:0]  r_rs;
    logic [DATA_W-1:0]  r_rt;
    logic [RADDR_W-1:0] r_rt_addr;
    logic [RADDR_W-1:0] r_rd_addr;
    logic [DATA_W-1:0]  r_imm;

    // Clear only kills the control bits; payload may stay stale in a bubble.
    always_ff @(negedge clk) begin
        if (!rst_n) begin
            r_valid   <= 1'b0;
            r_ctrl    <= '0;
            r_rs      <= '0;
            r_rt      <= '0;
            r_rt_addr <= '0;
            r_rd_addr <= '0;
            r_imm     <= '0;
        end else if (clear) begin
            r_valid   <= 1'b0;
            r_ctrl    <= '0;
        end else if (load) begin
            r_valid   <= 1'b1;
            r_ctrl    <= d_ctrl;
            r_rs      <= d_rs;
            r_rt      <= d_rt;
            r_rt_addr <= d_rt_addr;
            r_rd_addr <= d_rd_addr;
            r_imm     <= d_imm;
        end
    end

    assign valid     = r_valid;
    assign q_ctrl    = r_ctrl;
    assign q_rs      = r_rs;
    assign q_rt      = r_rt;
    assign q_rt_addr = r_rt_addr;
    assign q_rd_addr = r_rd_addr;
    assign q_imm     = r_imm;

endmodule : pipe_entry_reg
`default_nettype wire

// File: rtl/id_ex_skid_stage.sv
`default_nettype none
// ============================================================================
// Module   : id_ex_skid_stage
// Brief    : ID->EX register with valid/ready, skid entry, flush, stall count.
// Revision : 1.0 - initial release
// ============================================================================
module id_ex_skid_stage
    import pipe_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int RADDR_W = 5,
    parameter int CTRL_W  = pipe_pkg::CTRL_W,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [CTRL_W-1:0]  in_ctrl,
    input  logic [DATA_W-1:0]  in_rs,
    input  logic [DATA_W-1:0]  in_rt,
    input  logic [RADDR_W-1:0] in_rt_addr,
    input  logic [RADDR_W-1:0] in_rd_addr,
    input  logic [DATA_W-1:0]  in_imm,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [CTRL_W-1:0]  out_ctrl,
    output logic [DATA_W-1:0]  out_rs,
    output logic [DATA_W-1:0]  out_rt,
    output logic [RADDR_W-1:0] out_rt_addr,
    output logic [RADDR_W-1:0] out_rd_addr,
    output logic [DATA_W-1:0]  out_imm,
    output logic [CNT_W-1:0]   stall_cnt
);

    logic               w_m_valid;
    logic [CTRL_W-1:0]  w_m_ctrl;
    logic               w_s_valid;
    logic [CTRL_W-1:0]  w_s_ctrl;
    logic [DATA_W-1:0]  w_s_rs;
    logic [DATA_W-1:0]  w_s_rt;
    logic [RADDR_W-1:0] w_s_rt_addr;
    logic [RADDR_W-1:0] w_s_rd_addr;
    logic [DATA_W-1:0]  w_s_imm;

    logic               w_accept;
    logic               w_drain;
    logic               w_m_load;
    logic               w_m_clear;
    logic               w_m_from_skid;
    logic               w_s_load;
    logic               w_s_clear;
    logic               w_s_valid_nxt;

    logic [CTRL_W-1:0]  w_m_d_ctrl;
    logic [DATA_W-1:0]  w_m_d_rs;
    logic [DATA_W-1:0]  w_m_d_rt;
    logic [RADDR_W-1:0] w_m_d_rt_addr;
    logic [RADDR_W-1:0] w_m_d_rd_addr;
    logic [DATA_W-1:0]  w_m_d_imm;

    logic               r_in_ready;
    logic [CNT_W-1:0]   r_stall_cnt;

    assign w_accept = in_valid & r_in_ready;
    assign w_drain  = w_m_valid & out_ready;

    always_comb begin
        w_m_load      = 1'b0;
        w_m_clear     = 1'b0;
        w_m_from_skid = 1'b0;
        w_s_load      = 1'b0;
        w_s_clear     = 1'b0;
        if (flush) begin
            w_m_clear = 1'b1;
            w_s_clear = 1'b1;
        end else if (w_drain) begin
            if (w_s_valid) begin
                // in_ready is low whenever S is full, so no accept can race this move.
                w_m_load      = 1'b1;
                w_m_from_skid = 1'b1;
                w_s_clear     = 1'b1;
            end else if (w_accept) begin
                w_m_load = 1'b1;
            end else begin
                w_m_clear = 1'b1;
            end
        end else if (w_m_valid) begin
            w_s_load = w_accept;
        end else begin
            w_m_load = w_accept;
        end
    end

    always_comb begin
        w_s_valid_nxt = w_s_valid;
        if (w_s_clear) begin
            w_s_valid_nxt = 1'b0;
        end else if (w_s_load) begin
            w_s_valid_nxt = 1'b1;
        end
    end

    assign w_m_d_ctrl    = w_m_from_skid ? w_s_ctrl    : in_ctrl;
    assign w_m_d_rs      = w_m_from_skid ? w_s_rs      : in_rs;
    assign w_m_d_rt      = w_m_from_skid ? w_s_rt      : in_rt;
    assign w_m_d_rt_addr = w_m_from_skid ? w_s_rt_addr : in_rt_addr;
    assign w_m_d_rd_addr = w_m_from_skid ? w_s_rd_addr : in_rd_addr;
    assign w_m_d_imm     = w_m_from_skid ? w_s_imm     : in_imm;

    pipe_entry_reg #(
        .DATA_W  (DATA_W),
        .RADDR_W (RADDR_W),
        .CTRL_W  (CTRL_W)
    ) u_main (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (w_m_clear),
        .load      (w_m_load),
        .d_ctrl    (w_m_d_ctrl),
        .d_rs      (w_m_d_rs),
        .d_rt      (w_m_d_rt),
        .d_rt_addr (w_m_d_rt_addr),
        .d_rd_addr (w_m_d_rd_addr),
        .d_imm     (w_m_d_imm),
        .valid     (w_m_valid),
        .q_ctrl    (w_m_ctrl),
        .q_rs      (out_rs),
        .q_rt      (out_rt),
        .q_rt_addr (out_rt_addr),
        .q_rd_addr (out_rd_addr),
        .q_imm     (out_imm)
    );

    pipe_entry_reg #(
        .DATA_W  (DATA_W),
        .RADDR_W (RADDR_W),
        .CTRL_W  (CTRL_W)
    ) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (w_s_clear),
        .load      (w_s_load),
        .d_ctrl    (in_ctrl),
        .d_rs      (in_rs),
        .d_rt      (in_rt),
        .d_rt_addr (in_rt_addr),
        .d_rd_addr (in_rd_addr),
        .d_imm     (in_imm),
        .valid     (w_s_valid),
        .q_ctrl    (w_s_ctrl),
        .q_rs      (w_s_rs),
        .q_rt      (w_s_rt),
        .q_rt_addr (w_s_rt_addr),
        .q_rd_addr (w_s_rd_addr),
        .q_imm     (w_s_imm)
    );

    // Dedicated flop keeps in_ready free of any path from out_ready.
    always_ff @(negedge clk) begin
        if (!rst_n) begin
            r_in_ready <= 1'b1;
        end else begin
            r_in_ready <= ~w_s_valid_nxt;
        end
    end

    always_ff @(negedge clk) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
        end else if (w_m_valid && !out_ready && (r_stall_cnt != {CNT_W{1'b1}})) begin
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = w_m_valid;
    assign out_ctrl  = w_m_valid ? w_m_ctrl : '0;
    assign stall_cnt = r_stall_cnt;

endmodule : id_ex_skid_stage
`default_nettype wire

// File: doc/id_ex_skid_stage.md
Name: id_ex_skid_stage

Overview:
- Parametrised ID→EX pipeline register with valid/ready flow control, a one-entry skid buffer, flush-to-bubble, and a saturating stall counter.
- Sits between decode/register-read and the EX stage. Replaces the plain always-load stage register, so the pipeline can stall without losing an in-flight instruction.
- Control signals travel as one packed bundle.

Parameters:
- DATA_W, 32, width of rs/rt operand data and immediate
- RADDR_W, 5, register-address width (rt_addr, rd_addr)
- CTRL_W, 8, packed control bundle width (layout in shared package)
- CNT_W, 16, stall counter width

Ports:
- clk  in  1  clock; all state updates on falling edge, matching the other pipeline registers
- rst_n  in  1  synchronous active-low reset, sampled on the falling edge of clk
- flush  in  1  discard all held and incoming entries this edge
- in_valid  in  1  decode presents an instruction
- in_ready  out  1  stage can accept this edge
- in_ctrl  in  CTRL_W  packed control (RegDst, RegWrite, ALU_op, ALU_src, Mem_w, Mem_r, Mem_to_Reg)
- in_rs  in  DATA_W  rs operand
- in_rt  in  DATA_W  rt operand
- in_rt_addr  in  RADDR_W  rt address
- in_rd_addr  in  RADDR_W  rd address
- in_imm  in  DATA_W  sign-extended immediate
- out_valid  out  1  EX-side entry valid
- out_ready  in  1  EX consumes this edge
- out_ctrl, out_rs, out_rt, out_rt_addr, out_rd_addr, out_imm  out  as inputs  held entry fields
- stall_cnt  out  CNT_W  saturating count of edges with out_valid && !out_ready

Behaviour:
- Storage: main entry M (drives out_*) and skid entry S. Each entry has its own valid bit.
- in_ready = !S.valid. It is a registered bit, with no combinational path from out_ready.
- Reset (rst_n=0 at a falling edge):
  - M.valid = 0, S.valid = 0, stall_cnt = 0.
  - All out_* fields = 0, so out_ctrl = 0 and the stage emits a bubble.
  - in_ready = 1.
- Accept = in_valid && in_ready. Drain = out_valid && out_ready.
- Per falling edge, no flush (evaluate in this order):
  1. Drain && S.valid: M ← S, S.valid ← 0. If Accept also holds, that is impossible, because in_ready = 0.
  2. Drain && !S.valid:
     - Accept: M ← input, M.valid = 1.
     - No accept: M.valid ← 0 and M.ctrl ← 0.
  3. No drain, M.valid:
     - Accept: S ← input, S.valid = 1, and in_ready drops next cycle.
     - M unchanged.
  4. No drain, !M.valid:
     - Accept: M ← input.
     - No accept: M.ctrl held at 0.
- Latency: 1 edge from input to out_* when M is empty or draining.
- Throughput: 1 per cycle with out_ready held high.
- Bubble rule: whenever M.valid = 0, out_ctrl = 0, so RegWrite and Mem_w are never asserted on a bubble. Data fields may hold stale values.
- Flush = 1:
  - M.valid = S.valid = 0, out_ctrl = 0, and the incoming entry is dropped.
  - in_ready = 1 next cycle.
  - stall_cnt is unaffected by flush.
  - Flush takes priority over Accept and Drain on the same edge.
- Reset takes priority over flush.
- Reset mid-stall: all held entries are lost and the stage comes up empty.
- stall_cnt increments on each edge with out_valid && !out_ready, saturates at 2^CNT_W−1, and never wraps.
- Ordering: entries leave in acceptance order and are never duplicated or reordered.

Decomposition:
- Shared package pipe_pkg:
  - CTRL_W.
  - Bundle bit positions: REGDST=0, REGWRITE=1, ALUOP=3:2, ALUSRC=4, MEMW=5, MEMR=6, MEMTOREG=7.
  - CTRL_BUBBLE = 0.
- One natural sub-module: pipe_entry_reg. It holds one entry (valid + ctrl + payload) with load/clear controls and is instantiated twice, for M and S.

Test Plan:
- Reset with in_valid=1 and in_ctrl=8'hFF → out_valid=0, out_ctrl=0, in_ready=1, stall_cnt=0.
- Streaming with out_ready=1: three instructions with in_rs=1, 2, 3 on consecutive edges → out_rs=1, 2, 3 one edge later each; in_ready stays 1; stall_cnt stays 0.
- Stall:
  - Stimulus: out_ready=0 with two instructions A and B sent.
  - During the stall: M=A, S=B, in_ready=0 after the second edge, stall_cnt increments each edge.
  - Release out_ready → A, then B, appear in order; in_ready returns to 1.
- Flush during stall with M and S full and in_valid=1 → next edge: out_valid=0, out_ctrl=0, in_ready=1; the incoming instruction is never observed.
- Saturation with CNT_W=4: hold a stall for 20 edges → stall_cnt=15 and holds there.
- Reset mid-stall with both entries full → out_valid=0 and stall_cnt=0 after the edge; a fresh instruction passes with latency 1.
